// File: rtl/load_store_unit_pkg.sv
// Shared RV32 load/store types: access size encoding and the LSU state machine states.
package rv32_pkg;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        BYTE    = 2'b00,
        HALF    = 2'b01,
        WORD    = 2'b10,
        ILLEGAL = 2'b11
    } lsu_size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        REQ  = 2'b01,
        WAIT = 2'b10
    } lsu_state_e;
endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory bus between the LSU (master) and memory/interconnect (slave).
interface load_store_unit_if;
    import rv32_pkg::*;

    logic            req;
    logic            gnt;
    logic            we;
    logic [XLEN-1:0] addr;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            err;

    modport master (
        output req, we, addr, be, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, be, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for the LSU: alignment check, byte enables, store
// replication and load extraction with sign/zero extension.
module lsu_align
    import rv32_pkg::*;
(
    input  lsu_size_e       req_size,
    input  logic [1:0]      req_offset,
    input  lsu_size_e       acc_size,
    input  logic [1:0]      acc_offset,
    input  logic            acc_unsigned,
    input  logic [XLEN-1:0] acc_wdata,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            misaligned,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wdata_rep,
    output logic [XLEN-1:0] rdata_ext
);

    function automatic logic [XLEN-1:0] extend_load(
        input logic [XLEN-1:0] raw,
        input lsu_size_e       size,
        input logic            is_unsigned
    );
        logic signed [7:0]      b_s;
        logic signed [15:0]     h_s;
        logic signed [XLEN-1:0] r_s;
        b_s = $signed(raw[7:0]);
        h_s = $signed(raw[15:0]);
        case (size)
            BYTE:    r_s = is_unsigned ? $signed({24'h0, raw[7:0]})  : XLEN'(b_s);
            HALF:    r_s = is_unsigned ? $signed({16'h0, raw[15:0]}) : XLEN'(h_s);
            default: r_s = $signed(raw);
        endcase
        return r_s;
    endfunction

    logic [XLEN-1:0] rdata_shifted;

    always_comb begin
        case (req_size)
            BYTE:    misaligned = 1'b0;
            HALF:    misaligned = req_offset[0];
            WORD:    misaligned = |req_offset;
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        case (acc_size)
            BYTE: begin
                be        = 4'b0001 << acc_offset;
                wdata_rep = {4{acc_wdata[7:0]}};
            end
            HALF: begin
                be        = 4'b0011 << acc_offset;
                wdata_rep = {2{acc_wdata[15:0]}};
            end
            default: begin
                be        = 4'b1111;
                wdata_rep = acc_wdata;
            end
        endcase
    end

    // The addressed byte/half is moved down to bit 0 before extension.
    assign rdata_shifted = bus_rdata >> {acc_offset, 3'b000};
    assign rdata_ext     = extend_load(rdata_shifted, acc_size, acc_unsigned);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one outstanding bus access, stalls the pipeline
// until the response or a timeout, flags misaligned accesses without touching the bus.
module load_store_unit
    import rv32_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            lsu_req_i,
    input  logic            lsu_we_i,
    input  logic [1:0]      lsu_size_i,
    input  logic            lsu_unsigned_i,
    input  logic [XLEN-1:0] lsu_addr_i,
    input  logic [XLEN-1:0] lsu_wdata_i,
    output logic [XLEN-1:0] lsu_rdata_o,
    output logic            lsu_valid_o,
    output logic            lsu_err_o,
    output logic            data_stall_o,
    output logic            misaligned_access_o,
    output logic [XLEN-1:0] misaligned_addr_o,
    output logic            data_req_o,
    input  logic            data_gnt_i,
    output logic            data_we_o,
    output logic [XLEN-1:0] data_addr_o,
    output logic [3:0]      data_be_o,
    output logic [XLEN-1:0] data_wdata_o,
    input  logic            data_rvalid_i,
    input  logic [XLEN-1:0] data_rdata_i,
    input  logic            data_err_i
);

    localparam logic [CNT_W-1:0] TIMEOUT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    lsu_state_e      state_q;
    logic [XLEN-1:0] addr_q;
    logic            we_q;
    lsu_size_e       size_q;
    logic            unsigned_q;
    logic [XLEN-1:0] wdata_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] misaligned_addr_q;

    logic            misaligned;
    logic            accept;
    logic            rsp;
    logic            timeout;
    logic            bus_active;
    logic [3:0]      be;
    logic [XLEN-1:0] wdata_rep;
    logic [XLEN-1:0] rdata_ext;

    lsu_align u_align (
        .req_size     (lsu_size_e'(lsu_size_i)),
        .req_offset   (lsu_addr_i[1:0]),
        .acc_size     (size_q),
        .acc_offset   (addr_q[1:0]),
        .acc_unsigned (unsigned_q),
        .acc_wdata    (wdata_q),
        .bus_rdata    (data_rdata_i),
        .misaligned   (misaligned),
        .be           (be),
        .wdata_rep    (wdata_rep),
        .rdata_ext    (rdata_ext)
    );

    assign accept  = (state_q == IDLE) && lsu_req_i && !misaligned;
    assign rsp     = (state_q == WAIT) && data_rvalid_i;
    // A response arriving in the limit cycle still completes normally.
    assign timeout = (state_q != IDLE) && (cnt_q == TIMEOUT_LIMIT) && !rsp;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q           <= IDLE;
            addr_q            <= '0;
            we_q              <= 1'b0;
            size_q            <= BYTE;
            unsigned_q        <= 1'b0;
            wdata_q           <= '0;
            cnt_q             <= '0;
            misaligned_addr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (lsu_req_i) begin
                        if (misaligned) begin
                            misaligned_addr_q <= lsu_addr_i;
                        end else begin
                            addr_q     <= lsu_addr_i;
                            we_q       <= lsu_we_i;
                            size_q     <= lsu_size_e'(lsu_size_i);
                            unsigned_q <= lsu_unsigned_i;
                            wdata_q    <= lsu_wdata_i;
                            cnt_q      <= '0;
                            state_q    <= REQ;
                        end
                    end
                end
                REQ: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (timeout)         state_q <= IDLE;
                    else if (data_gnt_i) state_q <= WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (rsp || timeout) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Bus outputs are only driven while a request is on the bus.
    assign bus_active   = (state_q == REQ) && !timeout;
    assign data_req_o   = bus_active;
    assign data_we_o    = bus_active && we_q;
    assign data_addr_o  = bus_active ? {addr_q[XLEN-1:2], 2'b00} : '0;
    assign data_be_o    = bus_active ? be : 4'b0000;
    assign data_wdata_o = bus_active ? wdata_rep : '0;

    assign lsu_valid_o  = rsp || timeout;
    assign lsu_err_o    = (rsp && data_err_i) || timeout;
    assign lsu_rdata_o  = (rsp && !data_err_i && !we_q) ? rdata_ext : '0;

    assign data_stall_o = rst_ni && (accept
                                     || ((state_q == REQ) && !timeout)
                                     || ((state_q == WAIT) && !data_rvalid_i && !timeout));

    assign misaligned_access_o = rst_ni && (state_q == IDLE) && lsu_req_i && misaligned;
    assign misaligned_addr_o   = misaligned_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a short timeout so abort paths are quick to reach.
module tb_load_store_unit;

    logic        clk;
    logic        rst_ni;
    logic        lsu_req;
    logic        lsu_we;
    logic [1:0]  lsu_size;
    logic        lsu_uns;
    logic [31:0] lsu_addr;
    logic [31:0] lsu_wdata;
    logic [31:0] lsu_rdata;
    logic        lsu_valid;
    logic        lsu_err;
    logic        stall;
    logic        mis;
    logic [31:0] mis_addr;

    int n_pass  = 0;
    int n_total = 0;

    load_store_unit_if bus();

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i               (clk),
        .rst_ni              (rst_ni),
        .lsu_req_i           (lsu_req),
        .lsu_we_i            (lsu_we),
        .lsu_size_i          (lsu_size),
        .lsu_unsigned_i      (lsu_uns),
        .lsu_addr_i          (lsu_addr),
        .lsu_wdata_i         (lsu_wdata),
        .lsu_rdata_o         (lsu_rdata),
        .lsu_valid_o         (lsu_valid),
        .lsu_err_o           (lsu_err),
        .data_stall_o        (stall),
        .misaligned_access_o (mis),
        .misaligned_addr_o   (mis_addr),
        .data_req_o          (bus.req),
        .data_gnt_i          (bus.gnt),
        .data_we_o           (bus.we),
        .data_addr_o         (bus.addr),
        .data_be_o           (bus.be),
        .data_wdata_o        (bus.wdata),
        .data_rvalid_i       (bus.rvalid),
        .data_rdata_i        (bus.rdata),
        .data_err_i          (bus.err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req   = 1'b1;
        lsu_we    = we;
        lsu_size  = size;
        lsu_uns   = uns;
        lsu_addr  = addr;
        lsu_wdata = wdata;
    endtask

    task automatic test_reset;
        rst_ni = 1'b0;
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        bus.gnt = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0; bus.err = 1'b0;
        #2;
        n_total++; if (stall !== 1'b0) $display("FAIL rst_stall got %b exp 0", stall); else n_pass++;
        n_total++; if (mis !== 1'b0) $display("FAIL rst_mis got %b exp 0", mis); else n_pass++;
        n_total++; if (bus.req !== 1'b0) $display("FAIL rst_req got %b exp 0", bus.req); else n_pass++;
        n_total++; if (lsu_valid !== 1'b0 || lsu_err !== 1'b0) $display("FAIL rst_valid_err got %b%b exp 00", lsu_valid, lsu_err); else n_pass++;
        n_total++; if (bus.be !== 4'b0000) $display("FAIL rst_be got %b exp 0000", bus.be); else n_pass++;
        n_total++; if (mis_addr !== 32'h0) $display("FAIL rst_mis_addr got %h exp 0", mis_addr); else n_pass++;
        tick;
        rst_ni  = 1'b1;
        lsu_req = 1'b0;
    endtask

    task automatic test_load_byte;
        tick;
        issue(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL lb_accept_stall got %b exp 1", stall); else n_pass++;
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.req !== 1'b1) $display("FAIL lb_req got %b exp 1", bus.req); else n_pass++;
        n_total++; if (bus.addr !== 32'h100) $display("FAIL lb_addr got %h exp 00000100", bus.addr); else n_pass++;
        n_total++; if (bus.be !== 4'b1000) $display("FAIL lb_be got %b exp 1000", bus.be); else n_pass++;
        n_total++; if (lsu_valid !== 1'b0) $display("FAIL lb_early_valid got %b exp 0", lsu_valid); else n_pass++;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h80FF_0000;
        #1;
        n_total++; if (lsu_valid !== 1'b1) $display("FAIL lb_valid got %b exp 1", lsu_valid); else n_pass++;
        n_total++; if (lsu_rdata !== 32'hFFFF_FF80) $display("FAIL lb_rdata got %h exp ffffff80", lsu_rdata); else n_pass++;
        n_total++; if (stall !== 1'b0) $display("FAIL lb_stall_done got %b exp 0", stall); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
        #1;
        n_total++; if (lsu_valid !== 1'b0 || lsu_rdata !== 32'h0) $display("FAIL lb_after got %b/%h exp 0/0", lsu_valid, lsu_rdata); else n_pass++;
    endtask

    task automatic test_store_half;
        tick;
        issue(1'b1, 2'b01, 1'b0, 32'h202, 32'h0000_1234);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.be !== 4'b1100) $display("FAIL sh_be got %b exp 1100", bus.be); else n_pass++;
        n_total++; if (bus.wdata !== 32'h1234_1234) $display("FAIL sh_wdata got %h exp 12341234", bus.wdata); else n_pass++;
        n_total++; if (bus.we !== 1'b1 || bus.addr !== 32'h200) $display("FAIL sh_we_addr got %b/%h exp 1/00000200", bus.we, bus.addr); else n_pass++;
        tick;
        bus.gnt = 1'b0;
        #1;
        n_total++; if (stall !== 1'b1 || lsu_valid !== 1'b0) $display("FAIL sh_wait got %b/%b exp stall 1 valid 0", stall, lsu_valid); else n_pass++;
        tick;
        bus.rvalid = 1'b1; bus.rdata = 32'hDEAD_BEEF;
        #1;
        n_total++; if (lsu_valid !== 1'b1 || stall !== 1'b0) $display("FAIL sh_done got %b/%b exp valid 1 stall 0", lsu_valid, stall); else n_pass++;
        n_total++; if (lsu_rdata !== 32'h0) $display("FAIL sh_rdata got %h exp 0", lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
    endtask

    task automatic test_misaligned;
        issue(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
        #1;
        n_total++; if (mis !== 1'b1) $display("FAIL mis_lw got %b exp 1", mis); else n_pass++;
        n_total++; if (bus.req !== 1'b0 || stall !== 1'b0) $display("FAIL mis_lw_bus got %b/%b exp req 0 stall 0", bus.req, stall); else n_pass++;
        tick;
        lsu_req = 1'b0;
        #1;
        n_total++; if (mis_addr !== 32'h6) $display("FAIL mis_addr got %h exp 00000006", mis_addr); else n_pass++;
        n_total++; if (mis !== 1'b0 || bus.req !== 1'b0) $display("FAIL mis_after got %b/%b exp 0/0", mis, bus.req); else n_pass++;
        issue(1'b0, 2'b01, 1'b0, 32'h3, 32'h0);
        #1;
        n_total++; if (mis !== 1'b1) $display("FAIL mis_lh got %b exp 1", mis); else n_pass++;
        issue(1'b0, 2'b11, 1'b0, 32'h40, 32'h0);
        #1;
        n_total++; if (mis !== 1'b1 || stall !== 1'b0) $display("FAIL mis_size11 got %b/%b exp mis 1 stall 0", mis, stall); else n_pass++;
        tick;
        lsu_req = 1'b0;
        #1;
        n_total++; if (mis_addr !== 32'h40 || bus.req !== 1'b0) $display("FAIL mis_size11_addr got %h/%b exp 00000040/0", mis_addr, bus.req); else n_pass++;
    endtask

    task automatic test_grant_delay;
        tick;
        issue(1'b0, 2'b10, 1'b0, 32'h44, 32'h0);
        tick;
        lsu_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if (bus.req !== 1'b1 || bus.addr !== 32'h44 || bus.be !== 4'b1111 || stall !== 1'b1)
                $display("FAIL gnt_hold%0d got req %b addr %h be %b stall %b exp 1/00000044/1111/1", i, bus.req, bus.addr, bus.be, stall);
            else n_pass++;
            tick;
        end
        bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.req !== 1'b1 || bus.addr !== 32'h44) $display("FAIL gnt_cycle got %b/%h exp 1/00000044", bus.req, bus.addr); else n_pass++;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h1122_3344;
        #1;
        n_total++; if (lsu_valid !== 1'b1 || lsu_err !== 1'b0) $display("FAIL gnt_done got %b/%b exp valid 1 err 0", lsu_valid, lsu_err); else n_pass++;
        n_total++; if (lsu_rdata !== 32'h1122_3344) $display("FAIL gnt_rdata got %h exp 11223344", lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
    endtask

    task automatic test_bus_error;
        issue(1'b0, 2'b10, 1'b0, 32'h8, 32'h0);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.err = 1'b1; bus.rdata = 32'h5555_5555;
        #1;
        n_total++; if (lsu_valid !== 1'b1 || lsu_err !== 1'b1) $display("FAIL err_pulse got %b/%b exp 1/1", lsu_valid, lsu_err); else n_pass++;
        n_total++; if (lsu_rdata !== 32'h0) $display("FAIL err_rdata got %h exp 0", lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b0; bus.err = 1'b0;
        #1;
        n_total++; if (lsu_err !== 1'b0) $display("FAIL err_after got %b exp 0", lsu_err); else n_pass++;
    endtask

    task automatic test_back_to_back;
        issue(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'hBEEF_0000;
        #1;
        n_total++; if (lsu_rdata !== 32'h0000_BEEF) $display("FAIL b2b_lhu got %h exp 0000beef", lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
        issue(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL b2b_accept got %b exp 1", stall); else n_pass++;
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.be !== 4'b0011 || bus.addr !== 32'h0) $display("FAIL b2b_lh_bus got %b/%h exp 0011/00000000", bus.be, bus.addr); else n_pass++;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_8001;
        #1;
        n_total++; if (lsu_valid !== 1'b1 || lsu_rdata !== 32'hFFFF_8001) $display("FAIL b2b_lh got %b/%h exp 1/ffff8001", lsu_valid, lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
        issue(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.be !== 4'b0010) $display("FAIL b2b_lbu_be got %b exp 0010", bus.be); else n_pass++;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0000_A500;
        #1;
        n_total++; if (lsu_rdata !== 32'h0000_00A5) $display("FAIL b2b_lbu got %h exp 000000a5", lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
    endtask

    task automatic test_store_word;
        issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hCAFE_F00D);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.be !== 4'b1111 || bus.wdata !== 32'hCAFE_F00D) $display("FAIL sw_bus got %b/%h exp 1111/cafef00d", bus.be, bus.wdata); else n_pass++;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1; bus.rdata = 32'h0;
        tick;
        bus.rvalid = 1'b0;
        issue(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        #1;
        n_total++; if (bus.be !== 4'b0010 || bus.wdata !== 32'hABAB_ABAB) $display("FAIL sb_bus got %b/%h exp 0010/abababab", bus.be, bus.wdata); else n_pass++;
        tick;
        bus.gnt = 1'b0; bus.rvalid = 1'b1;
        tick;
        bus.rvalid = 1'b0;
    endtask

    task automatic test_timeout;
        issue(1'b0, 2'b10, 1'b0, 32'hC, 32'h0);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        tick;
        bus.gnt = 1'b0;
        for (int i = 1; i < 4; i++) begin
            #1;
            n_total++;
            if (lsu_valid !== 1'b0 || lsu_err !== 1'b0 || stall !== 1'b1)
                $display("FAIL to_wait%0d got valid %b err %b stall %b exp 0/0/1", i, lsu_valid, lsu_err, stall);
            else n_pass++;
            tick;
        end
        #1;
        n_total++; if (lsu_valid !== 1'b1 || lsu_err !== 1'b1) $display("FAIL to_pulse got %b/%b exp 1/1", lsu_valid, lsu_err); else n_pass++;
        n_total++; if (stall !== 1'b0 || lsu_rdata !== 32'h0) $display("FAIL to_stall got %b/%h exp 0/0", stall, lsu_rdata); else n_pass++;
        tick;
        bus.rvalid = 1'b1; bus.rdata = 32'h7777_7777;
        #1;
        n_total++; if (lsu_valid !== 1'b0 || stall !== 1'b0 || bus.req !== 1'b0) $display("FAIL to_idle got valid %b stall %b req %b exp 0/0/0", lsu_valid, stall, bus.req); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
    endtask

    task automatic test_reset_mid;
        issue(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        tick;
        lsu_req = 1'b0; bus.gnt = 1'b1;
        tick;
        bus.gnt = 1'b0;
        #1;
        n_total++; if (stall !== 1'b1) $display("FAIL rm_wait_stall got %b exp 1", stall); else n_pass++;
        rst_ni = 1'b0;
        #1;
        n_total++; if (stall !== 1'b0 || bus.req !== 1'b0 || mis_addr !== 32'h0) $display("FAIL rm_in_reset got stall %b req %b maddr %h exp 0/0/0", stall, bus.req, mis_addr); else n_pass++;
        tick;
        tick;
        rst_ni = 1'b1;
        tick;
        bus.rvalid = 1'b1; bus.rdata = 32'h1234_5678;
        #1;
        n_total++; if (lsu_valid !== 1'b0 || lsu_err !== 1'b0) $display("FAIL rm_stray got %b/%b exp 0/0", lsu_valid, lsu_err); else n_pass++;
        n_total++; if (lsu_rdata !== 32'h0 || stall !== 1'b0) $display("FAIL rm_outputs got %h/%b exp 0/0", lsu_rdata, stall); else n_pass++;
        tick;
        bus.rvalid = 1'b0;
    endtask

    initial begin
        test_reset;
        test_load_byte;
        test_store_half;
        test_misaligned;
        test_grant_delay;
        test_bus_error;
        test_back_to_back;
        test_store_word;
        test_timeout;
        test_reset_mid;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
